// File: rtl/boot_sequencer_if.sv
// Loader-stream and instruction-memory write port of the boot sequencer.
// The sequencer takes the slave side; the loader/memory environment the master side.
interface boot_sequencer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
);
  logic                     ld_valid;
  logic [INSTR_WIDTH-1:0]   ld_data;
  logic                     ld_last;
  logic                     ld_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [INSTR_WIDTH-1:0]   mem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a program image into instruction memory, then releases the fetch unit.
// Optional macro BOOT_CHECKSUM_EN adds a trailing checksum beat that must match the word sum.
module boot_sequencer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int N             = 32
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic                  halt_req,
  boot_sequencer_if.slave       bus,
  output logic                  core_n_reset,
  output logic                  load,
  output logic [31:0]           run_cycles,
  output logic                  done,
  output logic                  err
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_wcnt;
  logic [31:0]   r_run_cycles;
  logic          r_done;

  logic w_acc;
  logic w_we;
  logic w_final;
  logic w_enter_load;

  assign w_acc        = (r_state == S_LOAD) && bus.ld_valid;
  assign w_final      = bus.ld_last || (r_wcnt == CW'(N - 1));
  assign w_enter_load = start && ((r_state == S_IDLE) || (r_state == S_HALT));

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        r_ck_phase;
  logic        r_err;

  // The checksum beat is accepted like a word but never reaches memory.
  assign w_we = w_acc && !r_ck_phase;
  assign err  = r_err;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= S_IDLE;
      r_wcnt       <= '0;
      r_run_cycles <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_sum        <= '0;
      r_ck_phase   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_acc) begin
            if (!r_ck_phase) begin
              r_sum  <= r_sum + 32'(bus.ld_data);
              r_wcnt <= r_wcnt + 1'b1;
              if (w_final) r_ck_phase <= 1'b1;
            end else if (32'(bus.ld_data) == r_sum) begin
              r_state <= S_RUN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_run_cycles <= r_run_cycles + 32'd1;
          if (halt_req) r_state <= S_HALT;
        end
        default: begin
          if (w_enter_load) begin
            r_state      <= S_LOAD;
            r_wcnt       <= '0;
            r_run_cycles <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_sum        <= '0;
            r_ck_phase   <= 1'b0;
          end
        end
      endcase
    end
  end
`else
  assign w_we = w_acc;
  assign err  = 1'b0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= S_IDLE;
      r_wcnt       <= '0;
      r_run_cycles <= '0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_acc) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (w_final) begin
              r_state <= S_RUN;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_run_cycles <= r_run_cycles + 32'd1;
          if (halt_req) r_state <= S_HALT;
        end
        default: begin
          if (w_enter_load) begin
            r_state      <= S_LOAD;
            r_wcnt       <= '0;
            r_run_cycles <= '0;
            r_done       <= 1'b0;
          end
        end
      endcase
    end
  end
`endif

  // Address and data are zeroed off-beat so the memory bus idles quiet.
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = w_we ? ADDRESS_WIDTH'({r_wcnt, 2'b00}) : '0;
  assign bus.mem_wdata = w_we ? bus.ld_data : '0;
  assign bus.ld_ready  = (r_state == S_LOAD);

  assign core_n_reset = (r_state == S_RUN) || (r_state == S_HALT);
  assign load         = (r_state == S_RUN);
  assign run_cycles   = r_run_cycles;
  assign done         = r_done;
endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: behavioural model checked every cycle plus literal expectations.
// Build with BOOT_CHECKSUM_EN defined to exercise the checksum beat as well.
module tb_boot_sequencer;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        core_n_reset, load, done, err;
  logic [31:0] run_cycles;

  boot_sequencer_if #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  boot_sequencer #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW), .N(NW)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .halt_req(halt_req),
    .bus(bus), .core_n_reset(core_n_reset), .load(load),
    .run_cycles(run_cycles), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: three activity flags (none set = idle), word tally, running sum.
  bit          m_loading = 0, m_running = 0, m_halted = 0;
  int          m_cnt = 0;
  bit          m_done = 0, m_err = 0, m_ckph = 0;
  int unsigned m_cycles = 0;
  int unsigned m_sum = 0;

  task automatic m_begin_load();
    m_loading = 1; m_running = 0; m_halted = 0;
    m_cnt = 0; m_done = 0; m_err = 0; m_cycles = 0; m_sum = 0; m_ckph = 0;
  endtask

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_loading = 0; m_running = 0; m_halted = 0;
      m_cnt = 0; m_done = 0; m_err = 0; m_cycles = 0; m_sum = 0; m_ckph = 0;
    end else if (m_loading) begin
      if (bus.ld_valid) begin
        if (!m_ckph) begin
          m_sum += bus.ld_data;
          m_cnt++;
          if (bus.ld_last || m_cnt == NW) begin
`ifdef BOOT_CHECKSUM_EN
            m_ckph = 1;
`else
            m_loading = 0; m_running = 1; m_done = 1;
`endif
          end
        end else begin
          m_loading = 0;
          if (bus.ld_data == m_sum) begin m_running = 1; m_done = 1; end
          else m_err = 1;
        end
      end
    end else if (m_running) begin
      m_cycles++;
      if (halt_req) begin m_running = 0; m_halted = 1; end
    end else if (start) begin
      m_begin_load();
    end
  end

  always @(negedge clk) begin
    bit exp_we;
    exp_we = m_loading && bus.ld_valid && !m_ckph;
    chk("ld_ready",     bus.ld_ready, m_loading);
    chk("mem_we",       bus.mem_we, exp_we);
    chk("mem_addr",     bus.mem_addr, exp_we ? 64'(m_cnt * 4) : 64'd0);
    chk("mem_wdata",    bus.mem_wdata, exp_we ? 64'(bus.ld_data) : 64'd0);
    chk("core_n_reset", core_n_reset, m_running || m_halted);
    chk("load",         load, m_running);
    chk("run_cycles",   run_cycles, m_cycles);
    chk("done",         done, m_done);
    chk("err",          err, m_err);
  end

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  always @(negedge clk) if (bus.mem_we) begin
    wq_addr.push_back(bus.mem_addr);
    wq_data.push_back(bus.mem_wdata);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input bit last);
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    tick();
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
  endtask

  task automatic ck_beat(input logic [31:0] s);
`ifdef BOOT_CHECKSUM_EN
    beat(s, 1'b0);
`else
    if (s == 32'hFFFF_FFFF) tick();
`endif
  endtask

  task automatic halt_then_start();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    pulse_start();
  endtask

  initial begin
    logic [31:0] prog [4];
    logic [31:0] sum;
    prog[0] = 32'h13; prog[1] = 32'h93; prog[2] = 32'h113; prog[3] = 32'h193;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;

    #1 n_reset = 1'b0;
    tick(); tick();
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_core_n_reset", core_n_reset, 0);
    chk("rst_run_cycles", run_cycles, 0);
    n_reset = 1'b1;
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("idle_halt_ignored", bus.ld_ready, 0);

    // Four-word image with ld_last on the last word
    pulse_start();
    chk("t1_ld_ready", bus.ld_ready, 1);
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 4; i++) beat(prog[i], i == 3);
    ck_beat(32'h34C);
    chk("t1_done", done, 1);
    chk("t1_load", load, 1);
    chk("t1_core_n_reset", core_n_reset, 1);
    chk("t1_nwr", wq_addr.size(), 4);
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      chk("t1_addr", wq_addr[i], 32'(i * 4));
      chk("t1_data", wq_data[i], prog[i]);
    end

    // Run 10 cycles, then halt together with start
    repeat (9) tick();
    halt_req = 1'b1; start = 1'b1; tick(); halt_req = 1'b0; start = 1'b0;
    chk("t4_run_cycles", run_cycles, 10);
    chk("t4_load", load, 0);
    chk("t4_ld_ready", bus.ld_ready, 0);
    chk("t4_core_n_reset", core_n_reset, 1);
    repeat (3) tick();
    chk("t4_hold", run_cycles, 10);
    pulse_start();
    chk("t4_reload_cycles", run_cycles, 0);
    chk("t4_reload_ready", bus.ld_ready, 1);

    // Full-depth image without ld_last
    wq_addr.delete(); wq_data.delete();
    sum = 0;
    for (int i = 0; i < NW; i++) begin
      beat(32'(i * 4 + 7), 1'b0);
      sum += 32'(i * 4 + 7);
    end
`ifndef BOOT_CHECKSUM_EN
    chk("t2_run_next", load, 1);
`endif
    ck_beat(sum);
    chk("t2_load", load, 1);
    chk("t2_nwr", wq_addr.size(), 32);
    if (wq_addr.size() > 0) chk("t2_last_addr", wq_addr[wq_addr.size() - 1], 124);

    // ld_valid gaps during LOAD
    halt_then_start();
    wq_addr.delete(); wq_data.delete();
    beat(32'hA, 1'b0); tick();
    beat(32'hB, 1'b0); tick();
    beat(32'hC, 1'b1);
    ck_beat(32'h21);
    chk("t3_nwr", wq_addr.size(), 3);
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      chk("t3_addr", wq_addr[i], 32'(i * 4));
      chk("t3_data", wq_data[i], 32'hA + 32'(i));
    end
    chk("t3_done", done, 1);

    // Reset in the middle of a load
    halt_then_start();
    beat(prog[0], 1'b0);
    beat(prog[1], 1'b0);
    bus.ld_valid = 1'b1; bus.ld_data = prog[2];
    n_reset = 1'b0;
    #1;
    chk("t5_ld_ready", bus.ld_ready, 0);
    chk("t5_mem_we", bus.mem_we, 0);
    chk("t5_done", done, 0);
    chk("t5_load", load, 0);
    chk("t5_core_n_reset", core_n_reset, 0);
    bus.ld_valid = 1'b0; bus.ld_data = '0;
    tick();
    n_reset = 1'b1;
    tick();
    pulse_start();
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 4; i++) beat(prog[i], i == 3);
    ck_beat(32'h34C);
    chk("t5_nwr", wq_addr.size(), 4);
    if (wq_addr.size() > 0) chk("t5_first_addr", wq_addr[0], 0);
    chk("t5_done_after", done, 1);

`ifdef BOOT_CHECKSUM_EN
    halt_then_start();
    beat(32'd1, 1'b0); beat(32'd2, 1'b0); beat(32'd3, 1'b1);
    beat(32'd6, 1'b0);
    chk("t6_ok_load", load, 1);
    chk("t6_ok_done", done, 1);
    chk("t6_ok_err", err, 0);
    halt_then_start();
    wq_addr.delete(); wq_data.delete();
    beat(32'd1, 1'b0); beat(32'd2, 1'b0); beat(32'd3, 1'b1);
    beat(32'd7, 1'b0);
    chk("t6_bad_err", err, 1);
    chk("t6_bad_done", done, 0);
    chk("t6_bad_ready", bus.ld_ready, 0);
    chk("t6_bad_core", core_n_reset, 0);
    chk("t6_nwr", wq_addr.size(), 3);
    pulse_start();
    chk("t6_err_clear", err, 0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: instruction-memory byte-address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter N, default 32: instruction-memory depth in words, minimum 2.
REQ-004 SHALL have port clk, input, 1: single clock, all state changes on its rising edge.
REQ-005 SHALL have port n_reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: pulse; begins a program load.
REQ-007 SHALL have port halt_req, input, 1: stops execution.
REQ-008 SHALL have port ld_valid, input, 1: loader word valid.
REQ-009 SHALL have port ld_data, input, INSTR_WIDTH: loader word.
REQ-010 SHALL have port ld_last, input, 1: marks the final program word, qualified by ld_valid.
REQ-011 SHALL have port ld_ready, output, 1: sequencer accepts a loader word.
REQ-012 SHALL have port mem_we, output, 1: instruction-memory write enable.
REQ-013 SHALL have port mem_addr, output, ADDRESS_WIDTH: instruction-memory byte address.
REQ-014 SHALL have port mem_wdata, output, INSTR_WIDTH: instruction-memory write data.
REQ-015 SHALL have port core_n_reset, output, 1: active-low reset to the fetch unit.
REQ-016 SHALL have port load, output, 1: fetch-unit PC load enable.
REQ-017 SHALL have port run_cycles, output, 32: count of cycles spent in RUN.
REQ-018 SHALL have port done, output, 1: program image accepted.
REQ-019 SHALL have port err, output, 1: image rejected (sticky until next start).

Function
REQ-020 SHALL implement states IDLE, LOAD, RUN and HALT, with a registered state and a registered word counter of clog2(N)+1 bits.
REQ-021 IDLE: ld_ready=0, load=0, core_n_reset=0; start moves to LOAD, clears word counter, done and err.
REQ-022 LOAD: ld_ready=1, core_n_reset=0, load=0; a beat is accepted when ld_valid and ld_ready are both 1.
REQ-023 On an accepted beat, mem_we=1 combinationally in the same cycle, mem_addr=word_count*4, mem_wdata=ld_data, and the counter increments at the clock edge.
REQ-024 When a beat with ld_last=1 is accepted, or the Nth word is accepted, the next state is RUN and done is set to 1.
REQ-025 With ld_valid=0 in LOAD, mem_we=0 and the state holds indefinitely.
REQ-026 RUN: core_n_reset=1, load=1, ld_ready=0, mem_we=0, and run_cycles increments each cycle, wrapping from 0xFFFFFFFF to 0.
REQ-027 run_cycles SHALL clear on entry to LOAD.
REQ-028 RUN with halt_req=1 moves to HALT; halt_req wins over a simultaneous start.
REQ-029 HALT: load=0, core_n_reset=1 (PC frozen, not reset), run_cycles holds; start moves to LOAD.
REQ-030 start in LOAD or RUN, and halt_req in IDLE, LOAD or HALT, SHALL be ignored.
REQ-031 Outputs other than mem_we, mem_addr and mem_wdata SHALL be functions of registered state only.
REQ-032 mem_addr SHALL be 0 and mem_wdata SHALL be 0 whenever mem_we=0.

Reset
REQ-033 n_reset=0 SHALL immediately force IDLE, word counter 0, run_cycles 0, done 0, err 0, ld_ready 0, mem_we 0, load 0 and core_n_reset 0, including mid-LOAD or mid-RUN.
REQ-034 Memory contents already written are untouched by reset; a fresh start reloads from address 0.

Configuration
REQ-035 Macro BOOT_CHECKSUM_EN defined: LOAD accumulates a 32-bit wrapping sum of accepted words, and after the final word one extra beat is required as the checksum.
REQ-036 With BOOT_CHECKSUM_EN, the checksum beat SHALL NOT write memory; on a match the next state is RUN with done=1, and on a mismatch the next state is IDLE with err=1 and done=0.
REQ-037 Macro BOOT_CHECKSUM_EN undefined: there is no checksum beat and no accumulator, and err is tied to 0.

Verification
REQ-038 The bench SHALL cover: reset, start, 4 words 0x13,0x93,0x113,0x193 with ld_last on the 4th -> writes at addresses 0,4,8,12; done=1; RUN; load=1; core_n_reset=1.
REQ-039 The bench SHALL cover: N=32 words streamed without ld_last -> last write at address 124, then RUN on the next cycle.
REQ-040 The bench SHALL cover: ld_valid toggling 1-0-1 during LOAD -> mem_we high only on the valid cycles and the counter does not advance on gaps.
REQ-041 The bench SHALL cover: RUN for 10 cycles, then halt_req together with start -> HALT, run_cycles=10, load=0, start is ignored; a later start -> LOAD with run_cycles=0.
REQ-042 The bench SHALL cover: n_reset asserted after 2 of 4 load words -> IDLE immediately, ld_ready=0, done=0; a restart loads from address 0.
REQ-043 The bench SHALL cover, with BOOT_CHECKSUM_EN: words 1,2,3 then checksum 6 -> RUN; checksum 7 -> IDLE with err=1.
